vx_tag_sched: RTL and testbench

- Sequencer and arbiter in front of one bank's tag store (single-port tag RAM with registered read output).
- Shares the single tag-store port between three requesters: the fill path, the lookup path and a flush requester.
- Owns the line-by-line invalidation walk, both after reset and on a flush request.
- Drives the tag store's lookup/fill/flush/addr controls and returns lookup results one cycle after acceptance.

---
 rtl/vx_tag_sched.sv | 76 +++++++
 tb/tb_vx_tag_sched.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_tag_sched.sv
// vx_tag_sched: arbitrates fill/flush/lookup onto one tag-store port and runs the invalidation walks
module vx_tag_sched #(
  parameter int LINES_PER_BANK  = 64,
  parameter int LINE_ADDR_WIDTH = 26,
  parameter int REQ_IDW         = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       fill_valid,
  input  logic [LINE_ADDR_WIDTH-1:0] fill_addr,
  output logic                       fill_ready,
  input  logic                       lookup_valid,
  input  logic [LINE_ADDR_WIDTH-1:0] lookup_addr,
  input  logic [REQ_IDW-1:0]         lookup_id,
  output logic                       lookup_ready,
  input  logic                       flush_valid,
  output logic                       flush_ready,
  output logic                       flush_done,
  output logic                       rsp_valid,
  output logic [REQ_IDW-1:0]         rsp_id,
  output logic                       rsp_hit,
  output logic                       tag_lookup,
  output logic                       tag_fill,
  output logic                       tag_flush,
  output logic [LINE_ADDR_WIDTH-1:0] tag_addr,
  input  logic                       tag_match
);
  localparam int CW = $clog2(LINES_PER_BANK);
  localparam logic [1:0] S_INIT = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2;
  logic [1:0]         r_state;
  logic [CW-1:0]      r_ctr;
  logic               r_done;
  logic               r_rsp_valid;
  logic [REQ_IDW-1:0] r_rsp_id;
  logic               w_go, w_walk_go, w_run_go, w_last;
  // reset gates the combinational drive so the tag store sees no strobe while it is being reset
  assign w_go        = !stall && !reset;
  assign w_walk_go   = (r_state != S_RUN) && w_go;
  assign w_run_go    = (r_state == S_RUN) && w_go;
  assign w_last      = r_ctr == CW'(LINES_PER_BANK - 1);
  assign fill_ready   = w_run_go && fill_valid;
  assign flush_ready  = w_run_go && flush_valid && !fill_valid;
  assign lookup_ready = w_run_go && lookup_valid && !fill_valid && !flush_valid;
  assign tag_flush    = w_walk_go;
  assign tag_fill     = fill_ready;
  assign tag_lookup   = lookup_ready;
  assign tag_addr     = w_walk_go ? LINE_ADDR_WIDTH'(r_ctr) : fill_ready ? fill_addr :
                        lookup_ready ? lookup_addr : '0;
  assign flush_done   = r_done;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_id       = r_rsp_id;
  assign rsp_hit      = r_rsp_valid && tag_match;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_INIT;
      r_ctr       <= '0;
      r_done      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
    end else begin
      r_done <= w_walk_go && w_last;
      if (w_walk_go) begin
        r_ctr <= r_ctr + 1'b1;
        if (w_last) r_state <= S_RUN;
      end else if (flush_ready) begin
        r_state <= S_FLUSH;
        r_ctr   <= '0;
      end
      if (!stall) begin
        r_rsp_valid <= lookup_ready;
        if (lookup_ready) r_rsp_id <= lookup_id;
      end
    end
  end
endmodule

// File: tb/tb_vx_tag_sched.sv
// tb_vx_tag_sched: table, directed and random checks of vx_tag_sched against a cache-level reference model
module tb_vx_tag_sched;
  localparam int L  = 64;
  localparam int AW = 26;
  localparam int IW = 4;
  localparam int IB = $clog2(L);

  logic clk = 1'b0, reset = 1'b1, stall = 1'b0;
  logic fill_valid = 1'b0, lookup_valid = 1'b0, flush_valid = 1'b0;
  logic [AW-1:0] fill_addr = '0, lookup_addr = '0;
  logic [IW-1:0] lookup_id = '0;
  logic fill_ready, lookup_ready, flush_ready, flush_done, rsp_valid, rsp_hit;
  logic tag_lookup, tag_fill, tag_flush, tag_match;
  logic [IW-1:0] rsp_id;
  logic [AW-1:0] tag_addr;

  always #5 clk = ~clk;

  vx_tag_sched #(.LINES_PER_BANK(L), .LINE_ADDR_WIDTH(AW), .REQ_IDW(IW)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_ready(fill_ready),
    .lookup_valid(lookup_valid), .lookup_addr(lookup_addr), .lookup_id(lookup_id),
    .lookup_ready(lookup_ready), .flush_valid(flush_valid), .flush_ready(flush_ready),
    .flush_done(flush_done), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_hit(rsp_hit),
    .tag_lookup(tag_lookup), .tag_fill(tag_fill), .tag_flush(tag_flush),
    .tag_addr(tag_addr), .tag_match(tag_match)
  );

  // tag store: single port, registered match output, frozen by stall
  bit [L-1:0] ram_v;
  logic [AW-IB-1:0] ram_tag [L];
  logic match_q;
  assign tag_match = match_q;
  always @(posedge clk) begin
    if (reset) match_q <= 1'b0;
    else if (!stall) begin
      if (tag_flush) ram_v[tag_addr[IB-1:0]] <= 1'b0;
      if (tag_fill) begin
        ram_v[tag_addr[IB-1:0]]   <= 1'b1;
        ram_tag[tag_addr[IB-1:0]] <= tag_addr[AW-1:IB];
      end
      if (tag_lookup) match_q <= ram_v[tag_addr[IB-1:0]] && ram_tag[tag_addr[IB-1:0]] == tag_addr[AW-1:IB];
    end
  end

  int n_cmp = 0, n_bad = 0;

  // reference: which full line address each set holds, plus the walk position
  bit m_walk = 1'b1;
  int m_line = 0;
  bit m_done = 1'b0, m_rv = 1'b0, m_hit = 1'b0;
  logic [IW-1:0] m_rid = '0;
  bit mv [L];
  logic [AW-1:0] mt [L];

  logic s_fr, s_flr, s_lr, s_done, s_rv, s_hit, s_tf, s_tl, s_tfl;
  logic [AW-1:0] s_addr;
  logic [IW-1:0] s_rid;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    bit go, wg, fr, flr, lr;
    logic [AW-1:0] ea;
    @(negedge clk);
    go  = !stall && !reset;
    wg  = m_walk && go;
    fr  = !m_walk && go && fill_valid;
    flr = !m_walk && go && flush_valid && !fill_valid;
    lr  = !m_walk && go && lookup_valid && !fill_valid && !flush_valid;
    ea  = wg ? AW'(m_line) : fr ? fill_addr : lr ? lookup_addr : '0;
    s_fr = fill_ready; s_flr = flush_ready; s_lr = lookup_ready; s_done = flush_done;
    s_rv = rsp_valid; s_rid = rsp_id; s_hit = rsp_hit;
    s_tf = tag_flush; s_tl = tag_lookup; s_tfl = tag_fill; s_addr = tag_addr;
    chk("fill_ready", 32'(s_fr), 32'(fr));
    chk("flush_ready", 32'(s_flr), 32'(flr));
    chk("lookup_ready", 32'(s_lr), 32'(lr));
    chk("tag_flush", 32'(s_tf), 32'(wg));
    chk("tag_fill", 32'(s_tfl), 32'(fr));
    chk("tag_lookup", 32'(s_tl), 32'(lr));
    chk("tag_addr", 32'(s_addr), 32'(ea));
    chk("flush_done", 32'(s_done), 32'(m_done));
    chk("rsp_valid", 32'(s_rv), 32'(m_rv));
    chk("rsp_id", 32'(s_rid), 32'(m_rid));
    chk("rsp_hit", 32'(s_hit), 32'(m_rv && m_hit));
    @(posedge clk);
    if (reset) begin
      m_walk = 1'b1; m_line = 0; m_done = 1'b0; m_rv = 1'b0; m_rid = '0;
    end else begin
      m_done = wg && m_line == L - 1;
      if (go) begin
        m_rv = lr;
        if (lr) begin
          m_rid = lookup_id;
          m_hit = mv[lookup_addr[IB-1:0]] && mt[lookup_addr[IB-1:0]] == lookup_addr;
        end
      end
      if (wg) begin
        mv[m_line] = 1'b0;
        m_line = (m_line + 1) % L;
        m_walk = m_line != 0;
      end else if (fr) begin
        mv[fill_addr[IB-1:0]] = 1'b1;
        mt[fill_addr[IB-1:0]] = fill_addr;
      end else if (flr) begin
        m_walk = 1'b1; m_line = 0;
      end
    end
    #1;
  endtask

  task automatic idle();
    stall = 1'b0; fill_valid = 1'b0; lookup_valid = 1'b0; flush_valid = 1'b0;
  endtask

  task automatic lookup(input logic [AW-1:0] a, input logic [IW-1:0] id);
    idle(); lookup_valid = 1'b1; lookup_addr = a; lookup_id = id;
  endtask

  task automatic fill(input logic [AW-1:0] a);
    idle(); fill_valid = 1'b1; fill_addr = a;
  endtask

  task automatic wait_done(input string nm, input int budget, output int t, output int strobes, output int first_addr);
    strobes = 0; first_addr = -1;
    for (t = 1; t <= budget; t++) begin
      cyc();
      if (s_tf) begin
        if (first_addr < 0) first_addr = int'(s_addr);
        strobes++;
      end
      if (s_done) break;
    end
    if (t > budget) chk({nm, "_timeout"}, 32'(t), 32'(budget));
  endtask

  typedef struct packed {logic st, fv, flv, lv, efr, eflr, elr;} vec_t;
  vec_t tbl [9];

  initial begin
    int t, n, fa, nlr;
    tbl[0] = 7'b0000_000; tbl[1] = 7'b0100_100; tbl[2] = 7'b0001_001;
    tbl[3] = 7'b0101_100; tbl[4] = 7'b0110_100; tbl[5] = 7'b1111_000;
    tbl[6] = 7'b1001_000; tbl[7] = 7'b0111_100; tbl[8] = 7'b0011_010;
    @(posedge clk); #1;
    cyc(); cyc();
    reset = 1'b0;
    for (int i = 0; i < L; i++) begin
      cyc();
      chk("init_strobe", 32'(s_tf), 32'd1);
      chk("init_addr", 32'(s_addr), 32'(i));
    end
    fill(26'h123);
    cyc();
    chk("init_done", 32'(s_done), 32'd1);
    chk("run_fill_ready", 32'(s_fr), 32'd1);
    lookup(26'h123, 4'd5);
    cyc();
    lookup(26'h163, 4'd6);
    cyc();
    chk("b2b_valid", 32'(s_rv), 32'd1);
    chk("b2b_id", 32'(s_rid), 32'd5);
    chk("b2b_hit", 32'(s_hit), 32'd1);
    idle();
    cyc();
    chk("miss_id", 32'(s_rid), 32'd6);
    chk("miss_hit", 32'(s_hit), 32'd0);
    for (int i = 0; i < 9; i++) begin
      stall = tbl[i].st; fill_valid = tbl[i].fv; flush_valid = tbl[i].flv; lookup_valid = tbl[i].lv;
      fill_addr = AW'($urandom); lookup_addr = AW'($urandom); lookup_id = IW'($urandom);
      cyc();
      chk($sformatf("tbl%0d_fill", i), 32'(s_fr), 32'(tbl[i].efr));
      chk($sformatf("tbl%0d_flush", i), 32'(s_flr), 32'(tbl[i].eflr));
      chk($sformatf("tbl%0d_lookup", i), 32'(s_lr), 32'(tbl[i].elr));
    end
    idle();
    lookup_valid = 1'b1;
    nlr = 0; n = 0;
    for (t = 1; t <= 120; t++) begin
      stall = t >= 10 && t <= 14;
      cyc();
      if (s_tf) n++;
      if (s_done) break;
      if (s_lr) nlr++;
    end
    chk("stall_walk_len", 32'(t), 32'd70);
    chk("stall_walk_strobes", 32'(n), 32'd64);
    chk("walk_no_lookup", 32'(nlr), 32'd0);
    fill(26'h2A5);
    cyc();
    lookup(26'h2A5, 4'd9);
    cyc();
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1;
      cyc();
      chk("hold_valid", 32'(s_rv), 32'd1);
      chk("hold_id", 32'(s_rid), 32'd9);
      chk("hold_hit", 32'(s_hit), 32'd1);
    end
    idle(); flush_valid = 1'b1;
    cyc();
    chk("flush_accept", 32'(s_flr), 32'd1);
    idle();
    for (int i = 0; i < 30; i++) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    wait_done("reinit", 120, t, n, fa);
    chk("reinit_len", 32'(t), 32'd65);
    chk("reinit_strobes", 32'(n), 32'd64);
    chk("reinit_first_addr", 32'(fa), 32'd0);
    fill(26'h040);
    cyc();
    idle(); flush_valid = 1'b1;
    cyc();
    idle();
    wait_done("flush", 120, t, n, fa);
    lookup(26'h040, 4'd3);
    cyc();
    idle();
    cyc();
    chk("flushed_valid", 32'(s_rv), 32'd1);
    chk("flushed_hit", 32'(s_hit), 32'd0);
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(0, 499) == 0;
      stall = $urandom_range(0, 7) == 0;
      fill_valid = $urandom_range(0, 3) == 0;
      flush_valid = $urandom_range(0, 39) == 0;
      lookup_valid = $urandom_range(0, 1) == 1;
      fill_addr = AW'(($urandom_range(0, 3) << IB) | $urandom_range(0, 7));
      lookup_addr = AW'(($urandom_range(0, 3) << IB) | $urandom_range(0, 7));
      lookup_id = IW'($urandom);
      cyc();
    end
    reset = 1'b0; idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
